// File: rtl/cdc_req_sender.sv
// Transmit side of a 4-phase req/ack handshake: captures a word, holds it under req_out,
// and completes the cycle against a synchronized ack or an optional timeout.
module cdc_req_sender #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  send_valid,
   input  logic [DATA_WIDTH-1:0] send_data,
   output logic                  send_ready,
   output logic                  req_out,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  ack_async,
   output logic                  done_pulse,
   output logic                  timeout_pulse
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : gen_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end

   typedef enum logic [1:0] {StIdle, StReq, StWaitAckLow} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_s;
   logic                   req_q, req_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   aborted_q, aborted_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;

   assign ack_s = ack_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         ack_sync_q <= '0;
         req_q      <= 1'b0;
         data_q     <= '0;
         cnt_q      <= '0;
         aborted_q  <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
         req_q      <= req_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         aborted_q  <= aborted_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      aborted_d = aborted_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (send_valid) begin
               data_d    = send_data;
               req_d     = 1'b1;
               cnt_d     = '0;
               aborted_d = 1'b0;
               state_d   = StReq;
            end
         end
         StReq: begin
            // A synchronized ack wins over a timeout landing on the same edge.
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = StWaitAckLow;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               req_d     = 1'b0;
               timeout_d = 1'b1;
               aborted_d = 1'b1;
               state_d   = StWaitAckLow;
            end else if (TO_EN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StWaitAckLow: begin
            if (!ack_s) begin
               done_d  = ~aborted_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign send_ready    = (state_q == StIdle);
   assign req_out       = req_q;
   assign data_out      = data_q;
   assign done_pulse    = done_q;
   assign timeout_pulse = timeout_q;

endmodule
